ext_ram_arbiter: RTL
====================

Name: ext_ram_arbiter

Overview:
Shares the single nibble-serial external RAM port (4 address pins out, 4 data pins in) between two internal read requesters. Port 0 is the high-priority video fetch path; port 1 is the CPU/synth path. The block picks a requester, serialises a command and a 16-bit address, waits a fixed RAM latency, deserialises a 16-bit word and returns it with the port tag. It sits between the requesters and the top-level uio_out[3:0] / ui_in[3:0] pins.

Parameters:
RAM_LATENCY, 10, cycles from the last address nibble to the first data nibble; legal range 1..31.
STARVE_LIMIT, 3, consecutive port-0 grants allowed while port 1 is waiting before port 1 is forced; legal range 1..15.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 read request
req0_addr  in  16  port 0 word address
req0_ready  out  1  port 0 request accepted this cycle when high with req0_valid
req1_valid  in  1  port 1 read request
req1_addr  in  16  port 1 word address
req1_ready  out  1  port 1 accept
rsp_valid  out  1  one-cycle pulse, rsp_data valid
rsp_port  out  1  port that owns the response
rsp_data  out  16  read data
addr_out  out  4  serial command/address nibbles to RAM pins
data_in  in  4  serial data nibbles from RAM pins
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, addr_out=4'h0, rsp_valid=0, rsp_port=0, rsp_data=0, starve counter=0, busy=0. Assert mid-transaction: abort immediately, no response, no late rsp_valid after release.
- States: IDLE -> CMD -> ADDR (4 cycles) -> WAIT (RAM_LATENCY cycles) -> DATA (4 cycles) -> IDLE.
- Grant (combinational, only in IDLE): reqN_ready=1 only for the chosen port and only in IDLE; never both high. Choice: port 0 if req0_valid, unless req1_valid and starve counter==STARVE_LIMIT, then port 1; else port 1 if req1_valid.
- Starve counter: +1 on each port-0 accept while req1_valid is high; cleared on port-1 accept or when req1_valid is low at a port-0 accept; saturates at STARVE_LIMIT.
- Accept in cycle T (valid&&ready): address and port latched. addr_out (registered): T+1 = 4'h1 (read command); T+2..T+5 = addr[15:12], [11:8], [7:4], [3:0]; 4'h0 in all other cycles, including IDLE/WAIT/DATA.
- data_in nibble k (k=0..3, MSB nibble first) sampled at the clock edge ending cycle T+5+RAM_LATENCY+k.
- rsp_valid=1 for exactly cycle T+RAM_LATENCY+9, with rsp_port and rsp_data; rsp_data/rsp_port hold their values until the next response. State is IDLE in that same cycle, so a new accept can occur then. Minimum request-to-request spacing: RAM_LATENCY+9 cycles.
- Requests are not pipelined; a requester holding valid while not ready must keep its address stable. Valid dropped before accept is simply not served.
- Simultaneous req0/req1 with counter below limit: port 0 wins, port 1 keeps waiting.

Test Plan:
- Reset, then single port-1 read addr 16'h1234, RAM_LATENCY=10, RAM model returns 16'hBEEF -> addr_out 1,1,2,3,4 in cycles T+1..T+5; rsp_valid only in T+19, rsp_port=1, rsp_data=16'hBEEF.
- Both ports valid continuously, STARVE_LIMIT=3 -> grant order 0,0,0,1,0,0,0,1; accepts spaced exactly 19 cycles; no cycle with both readys high.
- Port 0 only, back-to-back addresses 16'h0000, 16'hFFFF -> second accept in the same cycle as first rsp_valid; addr_out F,F,F,F nibbles for second; data correct per address.
- rst_n pulsed low during WAIT of a port-0 read -> addr_out=0, busy=0 immediately; no rsp_valid ever appears for that read; next request served normally.
- req1_valid raised then dropped before grant while port 0 busy -> no port-1 transaction; starve counter clears on next port-0 accept with req1_valid low.
- RAM_LATENCY=1 instance -> rsp_valid at T+10 with correct data.

Source files
------------

// File: rtl/ext_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ext_ram_arbiter_if
//   Bundle of everything that crosses the external RAM arbiter boundary
//   except clock and reset.
//
//   Requester side:
//     req0_valid / req0_addr / req0_ready : port 0 (video fetch, high priority)
//     req1_valid / req1_addr / req1_ready : port 1 (CPU/synth path)
//     rsp_valid / rsp_port / rsp_data     : read response, one-cycle pulse
//   RAM pin side:
//     addr_out : serial command/address nibbles towards the RAM
//     data_in  : serial data nibbles from the RAM
//   Status:
//     busy     : arbiter is not idle
//
//   Modports: slave = arbiter view, master = requester/RAM/system view.
// ---------------------------------------------------------------------------
interface ext_ram_arbiter_if;
    logic        req0_valid;
    logic [15:0] req0_addr;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_addr;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_port;
    logic [15:0] rsp_data;
    logic [3:0]  addr_out;
    logic [3:0]  data_in;
    logic        busy;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, data_in,
        output req0_ready, req1_ready, rsp_valid, rsp_port, rsp_data,
               addr_out, busy
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, data_in,
        input  req0_ready, req1_ready, rsp_valid, rsp_port, rsp_data,
               addr_out, busy
    );
endinterface

// File: rtl/ext_ram_arbiter.sv
// ---------------------------------------------------------------------------
// ext_ram_arbiter
//   Shares one nibble-serial external RAM port between two read requesters.
//   A granted request is serialised as a read command nibble followed by four
//   address nibbles (MSB first), the RAM latency is waited out, four data
//   nibbles are collected (MSB first) and the word is returned with its tag.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset, aborts any transfer in flight
//   bus   : ext_ram_arbiter_if.slave (request/response handshake + RAM pins)
//
// Handshake: a request is accepted in the cycle where reqN_valid and
// reqN_ready are both high. reqN_ready is combinational, only ever high in
// IDLE, only for the chosen port, and never for both ports at once. A
// requester holding valid without ready must keep its address stable; a
// valid dropped before acceptance is simply not served. rsp_valid is a
// one-cycle pulse; rsp_port/rsp_data hold until the next response.
//
// Parameters:
//   RAM_LATENCY  : cycles from the last address nibble to the first data
//                  nibble (1..31)
//   STARVE_LIMIT : consecutive port-0 grants tolerated while port 1 waits
//                  before port 1 is forced (1..15)
// ---------------------------------------------------------------------------
module ext_ram_arbiter #(
    parameter int RAM_LATENCY  = 10,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    ext_ram_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        WAIT = 3'd3,
        DATA = 3'd4
    } state_t;

    localparam logic [3:0] READ_CMD  = 4'h1;
    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
    // The first data nibble is sampled in the first DATA cycle, so WAIT only
    // has to cover RAM_LATENCY-1 cycles; with RAM_LATENCY==1 it is skipped.
    localparam logic [4:0] WAIT_LAST = 5'(RAM_LATENCY - 2);
    localparam bit         HAS_WAIT  = (RAM_LATENCY > 1);

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic        grant0, grant1;
    logic        sample, last_nibble;
    logic [3:0]  addr_out_nxt;

    logic [15:0] addr_q;
    logic        port_q;
    logic [11:0] shift_q;
    logic [3:0]  starve_q;
    logic [3:0]  addr_out_q;
    logic        rsp_valid_q;
    logic        rsp_port_q;
    logic [15:0] rsp_data_q;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state, grant and the value addr_out takes next cycle
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        addr_out_nxt = 4'h0;
        grant0       = 1'b0;
        grant1       = 1'b0;
        sample       = 1'b0;
        last_nibble  = 1'b0;
        case (state)
            IDLE: begin
                // Port 1 preempts only once port 0 has used up its quota.
                if (bus.req1_valid && (starve_q == LIMIT)) begin
                    grant1 = 1'b1;
                end else if (bus.req0_valid) begin
                    grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_nxt    = CMD;
                    cnt_nxt      = 5'd0;
                    addr_out_nxt = READ_CMD;
                end
            end
            CMD: begin
                state_nxt    = ADDR;
                cnt_nxt      = 5'd0;
                addr_out_nxt = addr_q[15:12];
            end
            ADDR: begin
                // addr_out already shows nibble cnt; queue up nibble cnt+1.
                cnt_nxt = cnt + 5'd1;
                case (cnt[1:0])
                    2'd0:    addr_out_nxt = addr_q[11:8];
                    2'd1:    addr_out_nxt = addr_q[7:4];
                    2'd2:    addr_out_nxt = addr_q[3:0];
                    default: addr_out_nxt = 4'h0;
                endcase
                if (cnt[1:0] == 2'd3) begin
                    cnt_nxt   = 5'd0;
                    state_nxt = HAS_WAIT ? WAIT : DATA;
                end
            end
            WAIT: begin
                cnt_nxt = cnt + 5'd1;
                if (cnt == WAIT_LAST) begin
                    cnt_nxt   = 5'd0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                sample  = 1'b1;
                cnt_nxt = cnt + 5'd1;
                if (cnt[1:0] == 2'd3) begin
                    last_nibble = 1'b1;
                    cnt_nxt     = 5'd0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 5'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, serial pins, response, starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= 16'h0000;
            port_q      <= 1'b0;
            shift_q     <= 12'h000;
            starve_q    <= 4'h0;
            addr_out_q  <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_data_q  <= 16'h0000;
        end else begin
            addr_out_q  <= addr_out_nxt;
            rsp_valid_q <= last_nibble;

            if (grant0) begin
                addr_q <= bus.req0_addr;
                port_q <= 1'b0;
                // Only back-to-back port-0 wins against a waiting port 1 count.
                if (!bus.req1_valid) begin
                    starve_q <= 4'h0;
                end else if (starve_q != LIMIT) begin
                    starve_q <= starve_q + 4'd1;
                end
            end else if (grant1) begin
                addr_q   <= bus.req1_addr;
                port_q   <= 1'b1;
                starve_q <= 4'h0;
            end

            if (sample) begin
                shift_q <= {shift_q[7:0], bus.data_in};
            end
            if (last_nibble) begin
                rsp_data_q <= {shift_q, bus.data_in};
                rsp_port_q <= port_q;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.addr_out   = addr_out_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_port   = rsp_port_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = (state != IDLE);

endmodule
